// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: parallel load, logical shift and rotate, run as multi-cycle bursts.
// Optional registered even-parity output is compiled in when USR_PARITY_EN is defined.
module universal_shift_reg #(
  parameter  int N     = 4,
  localparam int AMT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [N-1:0]     parallel_in,
  input  logic             serial_in,
  output logic [N-1:0]     parallel_out,
  output logic             serial_out,
  output logic             busy,
`ifdef USR_PARITY_EN
  output logic             done,
  output logic             parity_out
`else
  output logic             done
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_SHR   = 3'b001,
    OP_SHL   = 3'b010,
    OP_LOAD  = 3'b011,
    OP_ROR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } op_t;

  state_t           state, state_n;
  op_t              op_q, op_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [AMT_W-1:0] amt_clamped;
  logic [N-1:0]     data_q, data_n;
  logic [N-1:0]     q, q_n;
  logic             sout, sout_n;
  logic [N-1:0]     step_q;
  logic             step_out;
  logic             busy_q, done_q;

  assign amt_clamped = (shift_amt > AMT_W'(N)) ? AMT_W'(N) : shift_amt;

  // Single-bit step for the latched op; serial_in is taken live on every step edge.
  always_comb begin
    step_q   = q;
    step_out = sout;
    unique case (op_q)
      OP_SHR: begin
        step_out = q[0];
        step_q   = {serial_in, q[N-1:1]};
      end
      OP_SHL: begin
        step_out = q[N-1];
        step_q   = {q[N-2:0], serial_in};
      end
      OP_ROR: begin
        step_out = q[0];
        step_q   = {q[0], q[N-1:1]};
      end
      OP_ROL: begin
        step_out = q[N-1];
        step_q   = {q[N-2:0], q[N-1]};
      end
      default: begin
        step_q   = q;
        step_out = sout;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt;
    data_n  = data_q;
    q_n     = q;
    sout_n  = sout;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          op_n    = op_t'(op);
          cnt_n   = amt_clamped;
          data_n  = parallel_in;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        unique case (op_q)
          OP_LOAD: begin
            q_n     = data_q;
            state_n = S_DONE;
          end
          OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            // cnt holds the steps still to do; a zero amount finishes at E1 untouched.
            if (cnt == '0) begin
              state_n = S_DONE;
            end else begin
              q_n    = step_q;
              sout_n = step_out;
              cnt_n  = cnt - AMT_W'(1);
              if (cnt == AMT_W'(1)) state_n = S_DONE;
            end
          end
          default: state_n = S_DONE;
        endcase
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      op_q   <= OP_HOLD;
      cnt    <= '0;
      data_q <= '0;
      q      <= '0;
      sout   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      op_q   <= op_n;
      cnt    <= cnt_n;
      data_q <= data_n;
      q      <= q_n;
      sout   <= sout_n;
      busy_q <= (state_n == S_RUN);
      done_q <= (state_n == S_DONE);
    end
  end

  assign parallel_out = q;
  assign serial_out   = sout;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef USR_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (!reset) parity_q <= 1'b0;
    else        parity_q <= ^q_n;
  end

  assign parity_out = parity_q;
`endif

endmodule
